// File: rtl/stack_pkg.sv
// Shared types and constants for the operand stack and its controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package stack_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    // Occupancy state; empty/full are decoded directly from this.
    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } stack_state_t;

    // Command priority: a higher encoding wins when several commands are
    // asserted in the same cycle (push > pop > tos).
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_TOS  = 2'd1,
        CMD_POP  = 2'd2,
        CMD_PUSH = 2'd3
    } stack_cmd_t;

    function automatic stack_cmd_t cmd_winner(input logic push, input logic pop, input logic tos);
        if (push)     return CMD_PUSH;
        else if (pop) return CMD_POP;
        else if (tos) return CMD_TOS;
        else          return CMD_NONE;
    endfunction

    // True when more than one command is asserted at once.
    function automatic logic cmd_conflict(input logic push, input logic pop, input logic tos);
        return (push & pop) | (push & tos) | (pop & tos);
    endfunction

endpackage

// File: rtl/stack_if.sv
// Command/data bundle between the controller (master) and the operand stack (slave).
// Latency: n/a (wires only).
// Backpressure: none; commands are accepted every cycle, errors are flagged sticky.
// Optional STACK_HWM_EN adds the high-water-mark output hwm.
interface stack_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              tos;
    logic              pop;
    logic              push;
    logic              MtoS;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] stack_out;
    logic [PTR_W:0]    sp;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;
    logic              cmd_err;
`ifdef STACK_HWM_EN
    logic [PTR_W:0]    hwm;
`endif

    modport master (
`ifdef STACK_HWM_EN
        input  hwm,
`endif
        output tos, pop, push, MtoS, mem_data, alu_res,
        input  stack_out, sp, empty, full, overflow, underflow, cmd_err
    );

    modport slave (
`ifdef STACK_HWM_EN
        output hwm,
`endif
        input  tos, pop, push, MtoS, mem_data, alu_res,
        output stack_out, sp, empty, full, overflow, underflow, cmd_err
    );

endinterface

// File: rtl/stack_ram.sv
// DEPTH x DATA_W stack storage: synchronous write, asynchronous read.
// Latency: write committed at the clock edge; read is combinational.
// Backpressure: none. Ports: clk, we/waddr/wdata, raddr -> rdata. Not reset.
module stack_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack: push from mem_data/alu_res, pop/tos into a registered stack_out.
// Latency: 1 cycle from pop/tos to stack_out; push visible to a pop on the next cycle.
// Backpressure: none; illegal push/pop/tos are dropped and latched in sticky flags.
// Ports: clk, rst (sync, active high), bus (stack_if.slave). STACK_HWM_EN adds bus.hwm.
module stack_unit
    import stack_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic    clk,
    input  logic    rst,
    stack_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] SP_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] SP_LAST = (PTR_W+1)'(DEPTH - 1);

    stack_state_t      state;
    logic [PTR_W:0]    sp_q;
    logic [DATA_W-1:0] out_q;
    logic              ovf_q;
    logic              und_q;
    logic              err_q;

    stack_cmd_t        cmd;
    logic              conflict;
    logic              we;
    logic [PTR_W-1:0]  waddr;
    logic [PTR_W-1:0]  raddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    assign cmd      = cmd_winner(bus.push, bus.pop, bus.tos);
    assign conflict = cmd_conflict(bus.push, bus.pop, bus.tos);

    // sp points one past the top entry; at sp==DEPTH the low bits wrap to 0,
    // so sp-1 in PTR_W bits still addresses the top entry correctly.
    assign waddr = sp_q[PTR_W-1:0];
    assign raddr = waddr - PTR_W'(1);
    assign wdata = bus.MtoS ? bus.mem_data : bus.alu_res;
    // Reset dominates: a push in the reset cycle must not touch storage.
    assign we    = !rst && (cmd == CMD_PUSH) && (state != S_FULL);

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
            sp_q  <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
            und_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (conflict) err_q <= 1'b1;
            case (cmd)
                CMD_PUSH: begin
                    if (state == S_FULL) begin
                        ovf_q <= 1'b1;
                    end else begin
                        sp_q  <= sp_q + SP_ONE;
                        state <= (sp_q == SP_LAST) ? S_FULL : S_PARTIAL;
                    end
                end
                CMD_POP: begin
                    if (state == S_EMPTY) begin
                        und_q <= 1'b1;
                    end else begin
                        out_q <= rdata;
                        sp_q  <= sp_q - SP_ONE;
                        state <= (sp_q == SP_ONE) ? S_EMPTY : S_PARTIAL;
                    end
                end
                CMD_TOS: begin
                    if (state == S_EMPTY) und_q <= 1'b1;
                    else                  out_q <= rdata;
                end
                default: ;
            endcase
        end
    end

    assign bus.stack_out = out_q;
    assign bus.sp        = sp_q;
    assign bus.empty     = (state == S_EMPTY);
    assign bus.full      = (state == S_FULL);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = und_q;
    assign bus.cmd_err   = err_q;

`ifdef STACK_HWM_EN
    // Tracks sp one cycle behind; sp never exceeds DEPTH, so hwm saturates there.
    logic [PTR_W:0] hwm_q;

    always_ff @(posedge clk) begin
        if (rst)               hwm_q <= '0;
        else if (sp_q > hwm_q) hwm_q <= sp_q;
    end

    assign bus.hwm = hwm_q;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with a reference model feeding an expected-result queue.
// Latency: each step drives at negedge and checks 1 time unit after the next posedge.
// Backpressure: none; every step produces exactly one expected record.
module tb_stack_unit;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    typedef struct {
        logic [7:0] so;
        logic [4:0] sp;
        logic       e;
        logic       f;
        logic       o;
        logic       u;
        logic       c;
        logic [4:0] hwm;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    exp_t       q[$];
    logic [7:0] m_mem [DEPTH];
    int         msp;
    logic [7:0] mout;
    bit         movf, mund, merr;
    int         mhwm;

    stack_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model predicts the post-edge state.
    task automatic step(input string name, input bit r, input bit pu, input bit po,
                        input bit to, input bit ms, input logic [7:0] md, input logic [7:0] ar);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst          = r;
        bus.push     = pu;
        bus.pop      = po;
        bus.tos      = to;
        bus.MtoS     = ms;
        bus.mem_data = md;
        bus.alu_res  = ar;
        if (r) begin
            msp = 0; mout = 8'h00; movf = 0; mund = 0; merr = 0; mhwm = 0;
        end else begin
            if (msp > mhwm) mhwm = msp;
            if (int'(pu) + int'(po) + int'(to) > 1) merr = 1;
            if (pu) begin
                if (msp == DEPTH) movf = 1;
                else begin
                    m_mem[msp] = ms ? md : ar;
                    msp++;
                end
            end else if (po || to) begin
                if (msp == 0) mund = 1;
                else begin
                    mout = m_mem[msp-1];
                    if (po) msp--;
                end
            end
        end
        e.so = mout; e.sp = 5'(msp); e.e = (msp == 0); e.f = (msp == DEPTH);
        e.o = movf; e.u = mund; e.c = merr; e.hwm = 5'(mhwm);
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk({name, ".stack_out"}, 32'(bus.stack_out), 32'(g.so));
        chk({name, ".sp"},        32'(bus.sp),        32'(g.sp));
        chk({name, ".empty"},     32'(bus.empty),     32'(g.e));
        chk({name, ".full"},      32'(bus.full),      32'(g.f));
        chk({name, ".overflow"},  32'(bus.overflow),  32'(g.o));
        chk({name, ".underflow"}, 32'(bus.underflow), 32'(g.u));
        chk({name, ".cmd_err"},   32'(bus.cmd_err),   32'(g.c));
`ifdef STACK_HWM_EN
        chk({name, ".hwm"},       32'(bus.hwm),       32'(g.hwm));
`endif
    endtask

    initial begin
        total = 0; bad = 0;
        msp = 0; mout = 8'h00; movf = 0; mund = 0; merr = 0; mhwm = 0;
        rst = 1'b1;
        bus.push = 0; bus.pop = 0; bus.tos = 0; bus.MtoS = 0;
        bus.mem_data = 8'h00; bus.alu_res = 8'h00;

        step("rst0", 1, 0, 0, 0, 0, 8'h00, 8'h00);
        step("rst1", 1, 0, 0, 0, 0, 8'h00, 8'h00);

        // Push from both sources, pop them back in LIFO order.
        step("push11", 0, 1, 0, 0, 1, 8'h11, 8'hEE);
        step("push22", 0, 1, 0, 0, 0, 8'hDD, 8'h22);
        step("pop22",  0, 0, 1, 0, 0, 8'h00, 8'h00);
        chk("pop22.const", 32'(bus.stack_out), 32'h22);
        step("pop11",  0, 0, 1, 0, 0, 8'h00, 8'h00);
        chk("pop11.const", 32'(bus.stack_out), 32'h11);
        chk("pop11.empty", 32'(bus.empty), 32'h1);

        // Underflow from empty; sticky across later legal pushes.
        step("rstA",   1, 0, 0, 0, 0, 8'h00, 8'h00);
        step("tosE",   0, 0, 0, 1, 0, 8'h00, 8'h00);
        chk("tosE.const", 32'(bus.underflow), 32'h1);
        step("popE",   0, 0, 1, 0, 0, 8'h00, 8'h00);
        step("pushU",  0, 1, 0, 0, 1, 8'h5A, 8'h00);
        step("idleU",  0, 0, 0, 0, 0, 8'h00, 8'h00);
        chk("idleU.const", 32'(bus.underflow), 32'h1);

        // Fill to DEPTH, overflow, then pop the last value.
        step("rstB",   1, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < DEPTH; i++)
            step($sformatf("fill%0d", i), 0, 1, 0, 0, 0, 8'h00, 8'(i));
        chk("fill.full", 32'(bus.full), 32'h1);
        step("pushF",  0, 1, 0, 0, 1, 8'hFF, 8'hFF);
        chk("pushF.sp", 32'(bus.sp), 32'd16);
        step("popF",   0, 0, 1, 0, 0, 8'h00, 8'h00);
        chk("popF.const", 32'(bus.stack_out), 32'd15);
        step("tosF",   0, 0, 0, 1, 0, 8'h00, 8'h00);

        // tos, then command conflicts.
        step("rstC",   1, 0, 0, 0, 0, 8'h00, 8'h00);
        step("push05", 0, 1, 0, 0, 1, 8'h05, 8'h00);
        step("tos05",  0, 0, 0, 1, 0, 8'h00, 8'h00);
        chk("tos05.const", 32'(bus.stack_out), 32'h05);
        step("pushpop",0, 1, 1, 0, 0, 8'h00, 8'h33);
        chk("pushpop.const", 32'(bus.cmd_err), 32'h1);
        step("poptos", 0, 0, 1, 1, 0, 8'h00, 8'h00);
        chk("poptos.const", 32'(bus.stack_out), 32'h33);
        step("all3",   0, 1, 1, 1, 1, 8'h66, 8'h77);
        step("pop66",  0, 0, 1, 0, 0, 8'h00, 8'h00);

        // Reset mid-sequence with a push pending.
        step("rstD",   1, 0, 0, 0, 0, 8'h00, 8'h00);
        step("d1",     0, 1, 0, 0, 0, 8'h00, 8'hA1);
        step("d2",     0, 1, 0, 0, 0, 8'h00, 8'hA2);
        step("d3",     0, 1, 0, 0, 0, 8'h00, 8'hA3);
        step("rstPush",1, 1, 0, 0, 1, 8'h77, 8'h77);
        chk("rstPush.sp", 32'(bus.sp), 32'd0);
        step("d4",     0, 1, 0, 0, 1, 8'h44, 8'h00);
        step("d5",     0, 0, 1, 0, 0, 8'h00, 8'h00);

        // High-water mark: push 5, pop 3, push 1.
        step("rstH",   1, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++)
            step($sformatf("h_push%0d", i), 0, 1, 0, 0, 0, 8'h00, 8'(8'h80 + i));
        for (int i = 0; i < 3; i++)
            step($sformatf("h_pop%0d", i), 0, 0, 1, 0, 0, 8'h00, 8'h00);
        step("h_push5", 0, 1, 0, 0, 0, 8'h00, 8'h90);
        step("h_idle",  0, 0, 0, 0, 0, 8'h00, 8'h00);
`ifdef STACK_HWM_EN
        chk("hwm.const", 32'(bus.hwm), 32'd5);
`endif
        step("h_rst",   1, 0, 0, 0, 0, 8'h00, 8'h00);
`ifdef STACK_HWM_EN
        chk("hwm.rst", 32'(bus.hwm), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
